// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch
//  Purpose  : Instruction-fetch initiator. Issues sequential word reads on the
//             ibus, buffers words with their PCs, supports redirect + flush.
//  Revision : 1.0
// ============================================================================
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ibus_addr,
    input  logic [31:0] ibus_data,
    output logic        ibus_valid,
    input  logic        ibus_ready,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        buf_data_q [FIFO_DEPTH];
    logic [31:0]        buf_pc_q   [FIFO_DEPTH];

    logic               w_grant;
    logic               w_pop;
    logic               w_push;
    logic [31:0]        w_redirect_pc;
    logic [31:0]        w_pc_inc;
    logic [CNT_W-1:0]   w_cnt_after_push;

    assign ibus_valid       = (state_q == REQ) || (state_q == DROP);
    assign ibus_addr        = req_addr_q;
    assign inst_valid       = (count_q != '0);
    assign inst_data        = inst_valid ? buf_data_q[rd_ptr_q] : 32'd0;
    assign inst_pc          = inst_valid ? buf_pc_q[rd_ptr_q]   : 32'd0;

    assign w_grant          = ibus_valid && ibus_ready;
    assign w_pop            = inst_valid && inst_ready;
    assign w_redirect_pc    = redirect_pc & ~32'h3;
    assign w_pc_inc         = pc_q + 32'd4;
    assign w_cnt_after_push = count_q + CNT_W'(1) - CNT_W'(w_pop);

    // Request FSM: an outstanding request is never withdrawn; a redirect
    // while waiting moves to DROP so the in-flight word is discarded on grant.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        w_push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = w_redirect_pc;
                end else if (count_q < C_DEPTH) begin
                    state_d    = REQ;
                    req_addr_d = pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d = w_redirect_pc;
                    if (w_grant) begin
                        req_addr_d = w_redirect_pc;
                    end else begin
                        state_d = DROP;
                    end
                end else if (w_grant) begin
                    w_push = 1'b1;
                    pc_d   = w_pc_inc;
                    if (w_cnt_after_push < C_DEPTH) begin
                        req_addr_d = w_pc_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_d = w_redirect_pc;
                end
                if (w_grant) begin
                    state_d    = REQ;
                    req_addr_d = pc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer bookkeeping; a redirect flushes and overrides any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            buf_data_q[wr_ptr_q] <= ibus_data;
            buf_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch
//  Purpose  : Directed self-checking bench for ifetch with a zero-wait ROM
//             model where mem[i] = i.
//  Revision : 1.0
// ============================================================================
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_data;
    logic        ibus_valid;
    logic        ibus_ready;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int checks = 0;
    int errors = 0;

    ifetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ibus_addr   (ibus_addr),
        .ibus_data   (ibus_data),
        .ibus_valid  (ibus_valid),
        .ibus_ready  (ibus_ready),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    assign ibus_data = ibus_addr >> 2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        ibus_ready  = 1'b1;
        inst_ready  = 1'b1;
        do_reset();
        checks++;
        if ({ibus_valid, ibus_addr, inst_valid, inst_data, inst_pc} !== {1'b0, 32'd0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b a=%h iv=%b d=%h pc=%h, want 0/0/0/0/0",
                     ibus_valid, ibus_addr, inst_valid, inst_data, inst_pc);
        end
    endtask

    task automatic test_stream();
        do_reset();
        tick();
        checks++;
        if ({ibus_valid, ibus_addr, inst_valid} !== {1'b1, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL stream_first_req: got v=%b a=%h iv=%b, want 1/0/0", ibus_valid, ibus_addr, inst_valid);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if ({ibus_addr, inst_valid, inst_pc, inst_data} !== {32'(4*k), 1'b1, 32'(4*(k-1)), 32'(k-1)}) begin
                errors++;
                $display("FAIL stream_%0d: got a=%h iv=%b pc=%h d=%h, want a=%h iv=1 pc=%h d=%h",
                         k, ibus_addr, inst_valid, inst_pc, inst_data, 4*k, 4*(k-1), k-1);
            end
        end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        do_reset();
        tick();
        tick();
        checks++;
        if ({ibus_valid, ibus_addr, inst_pc} !== {1'b1, 32'h4, 32'h0}) begin
            errors++;
            $display("FAIL bp_first_push: got v=%b a=%h pc=%h, want 1/4/0", ibus_valid, ibus_addr, inst_pc);
        end
        tick();
        checks++;
        if ({ibus_valid, inst_valid, inst_pc, inst_data} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL bp_full_idle: got v=%b iv=%b pc=%h d=%h, want 0/1/0/0", ibus_valid, inst_valid, inst_pc, inst_data);
        end
        tick();
        checks++;
        if ({ibus_valid, inst_pc} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL bp_hold: got v=%b pc=%h, want 0/0", ibus_valid, inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        checks++;
        if ({ibus_valid, inst_valid, inst_pc, inst_data} !== {1'b0, 1'b1, 32'h4, 32'h1}) begin
            errors++;
            $display("FAIL bp_second_word: got v=%b iv=%b pc=%h d=%h, want 0/1/4/1", ibus_valid, inst_valid, inst_pc, inst_data);
        end
        tick();
        checks++;
        if ({ibus_valid, ibus_addr, inst_valid} !== {1'b1, 32'h8, 1'b0}) begin
            errors++;
            $display("FAIL bp_resume: got v=%b a=%h iv=%b, want 1/8/0", ibus_valid, ibus_addr, inst_valid);
        end
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst_data, ibus_addr} !== {1'b1, 32'h8, 32'h2, 32'hC}) begin
            errors++;
            $display("FAIL bp_resume_word: got iv=%b pc=%h d=%h a=%h, want 1/8/2/c", inst_valid, inst_pc, inst_data, ibus_addr);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        tick();
        tick();
        tick();
        ibus_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ibus_valid, ibus_addr} !== {1'b1, 32'h8}) begin
                errors++;
                $display("FAIL wait_stable_%0d: got v=%b a=%h, want 1/8", k, ibus_valid, ibus_addr);
            end
            tick();
        end
        checks++;
        if ({ibus_valid, ibus_addr, inst_valid} !== {1'b1, 32'h8, 1'b0}) begin
            errors++;
            $display("FAIL wait_drained: got v=%b a=%h iv=%b, want 1/8/0", ibus_valid, ibus_addr, inst_valid);
        end
        ibus_ready = 1'b1;
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst_data, ibus_addr} !== {1'b1, 32'h8, 32'h2, 32'hC}) begin
            errors++;
            $display("FAIL wait_grant_push: got iv=%b pc=%h d=%h a=%h, want 1/8/2/c", inst_valid, inst_pc, inst_data, ibus_addr);
        end
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'hC, 32'h3}) begin
            errors++;
            $display("FAIL wait_no_dup: got iv=%b pc=%h d=%h, want 1/c/3", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        tick();
        tick();
        tick();
        ibus_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        checks++;
        if ({ibus_valid, ibus_addr, inst_valid} !== {1'b1, 32'h8, 1'b0}) begin
            errors++;
            $display("FAIL rdw_hold: got v=%b a=%h iv=%b, want 1/8/0", ibus_valid, ibus_addr, inst_valid);
        end
        tick();
        checks++;
        if ({ibus_valid, ibus_addr} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL rdw_hold2: got v=%b a=%h, want 1/8", ibus_valid, ibus_addr);
        end
        ibus_ready = 1'b1;
        tick();
        checks++;
        if ({ibus_valid, ibus_addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL rdw_discard: got v=%b a=%h iv=%b, want 1/100/0", ibus_valid, ibus_addr, inst_valid);
        end
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst_data, ibus_addr} !== {1'b1, 32'h100, 32'h40, 32'h104}) begin
            errors++;
            $display("FAIL rdw_target: got iv=%b pc=%h d=%h a=%h, want 1/100/40/104", inst_valid, inst_pc, inst_data, ibus_addr);
        end
    endtask

    task automatic test_redirect_grant();
        do_reset();
        tick();
        tick();
        tick();
        // Unaligned target: low two bits must be dropped.
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        tick();
        redirect = 1'b0;
        checks++;
        if ({inst_valid, ibus_valid, ibus_addr} !== {1'b0, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL rdg_flush: got iv=%b v=%b a=%h, want 0/1/40", inst_valid, ibus_valid, ibus_addr);
        end
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst_data, ibus_addr} !== {1'b1, 32'h40, 32'h10, 32'h44}) begin
            errors++;
            $display("FAIL rdg_target: got iv=%b pc=%h d=%h a=%h, want 1/40/10/44", inst_valid, inst_pc, inst_data, ibus_addr);
        end
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h44, 32'h11}) begin
            errors++;
            $display("FAIL rdg_next: got iv=%b pc=%h d=%h, want 1/44/11", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_pc_wrap();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++;
        if ({inst_valid, ibus_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_req: got iv=%b a=%h, want 0/fffffffc", inst_valid, ibus_addr);
        end
        tick();
        checks++;
        if ({inst_pc, inst_data, ibus_addr} !== {32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0}) begin
            errors++;
            $display("FAIL wrap_top: got pc=%h d=%h a=%h, want fffffffc/3fffffff/0", inst_pc, inst_data, ibus_addr);
        end
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst_data, ibus_addr} !== {1'b1, 32'h0, 32'h0, 32'h4}) begin
            errors++;
            $display("FAIL wrap_zero: got iv=%b pc=%h d=%h a=%h, want 1/0/0/4", inst_valid, inst_pc, inst_data, ibus_addr);
        end
    endtask

    task automatic test_reset_mid();
        inst_ready = 1'b0;
        do_reset();
        tick();
        tick();
        ibus_ready = 1'b0;
        checks++;
        if ({ibus_valid, ibus_addr, inst_valid} !== {1'b1, 32'h4, 1'b1}) begin
            errors++;
            $display("FAIL rstm_pre: got v=%b a=%h iv=%b, want 1/4/1", ibus_valid, ibus_addr, inst_valid);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({ibus_valid, ibus_addr, inst_valid, inst_data, inst_pc} !== {1'b0, 32'd0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL rstm_clear: got v=%b a=%h iv=%b d=%h pc=%h, want 0/0/0/0/0",
                     ibus_valid, ibus_addr, inst_valid, inst_data, inst_pc);
        end
        reset      = 1'b0;
        ibus_ready = 1'b1;
        inst_ready = 1'b1;
        tick();
        checks++;
        if ({ibus_valid, ibus_addr} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL rstm_restart: got v=%b a=%h, want 1/0", ibus_valid, ibus_addr);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_wait_states();
        test_redirect_wait();
        test_redirect_grant();
        test_pc_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
